// File: rtl/daisychain_pkg.sv
// Shared types and sizing for the daisy-chain controller and its chain model.
// DATA_LEN may be overridden with a +define; the chain needs at least two cells.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

package daisychain_pkg;

    localparam int DC_DATA_LEN = `DATA_LEN;
    localparam int CNT_W       = $clog2(DC_DATA_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2,
        RESP   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/daisychain_if.sv
// Host-side command/response port of the daisy-chain controller.
interface daisychain_if
    import daisychain_pkg::*;
#(
    parameter int W = DC_DATA_LEN
) ();

    // Valid/ready on both channels: a transfer happens on a rising clk edge where
    // valid and ready are both high. Once valid is raised, the sender holds valid
    // and its payload unchanged until that transfer; ready may change freely.
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_data;
    logic         cmd_update;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_data, cmd_update, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_update, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/daisychain_chain_word_shifter.sv
// Word buffers for one chain transfer: tx_q drains LSB first into the chain,
// while rx_q collects the chain's old contents from the top down.
module chain_word_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         serial_i,
    output logic         serial_o,
    output logic [W-1:0] par_o
);

    logic [W-1:0] tx_q, tx_d;
    logic [W-1:0] rx_q, rx_d;

    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (clear_i) begin
            tx_d = '0;
            rx_d = '0;
        end else if (load_i) begin
            tx_d = load_data_i;
        end else if (shift_i) begin
            tx_d = tx_q >> 1;
            rx_d = {serial_i, rx_q[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign serial_o = tx_q[0];
    assign par_o    = rx_q;

endmodule

// File: rtl/shift_register.sv
// Daisy-chained cell array: shifts toward cell 0 while enabled, so the first bit
// shifted in ends up in cell 0; update copies the cells to the parallel outputs.
module shift_register #(
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_in,
    input  logic                enable,
    input  logic                update,
    output logic                data_out,
    output logic [DATA_LEN-1:0] bit_out
);

    logic [DATA_LEN-1:0] cells_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cells_q <= '0;
            bit_out <= '0;
        end else begin
            if (enable) begin
                cells_q <= {data_in, cells_q[DATA_LEN-1:1]};
            end
            if (update) begin
                bit_out <= cells_q;
            end
        end
    end

    assign data_out = cells_q[0];

endmodule

// File: rtl/daisychain_controller.sv
// Sequencer that writes one word into the shift_register chain, optionally pulses
// update, and returns the chain's previous contents as a response.
module daisychain_controller
    import daisychain_pkg::*;
#(
    parameter int DATA_LEN = DC_DATA_LEN
) (
    input  logic        clk,
    input  logic        reset,
    daisychain_if.slave bus,
    output logic        chain_data_in,
    output logic        chain_enable,
    output logic        chain_update,
    input  logic        chain_data_out,
    output logic        busy,
    output ctrl_state_t dbg_state_o
);

    localparam int CW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_LEN - 1);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd_q, upd_d;

    logic          cmd_ready;
    logic          rsp_valid;
    logic          load;
    logic          shift;
    logic          tx_bit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        upd_d        = upd_q;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        chain_enable = 1'b0;
        chain_update = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    load    = 1'b1;
                    upd_d   = bus.cmd_update;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                chain_enable = 1'b1;
                shift        = 1'b1;
                // Counter holds on the final shift so it never wraps mid-command.
                if (cnt_q == LAST_CNT) begin
                    state_d = upd_q ? UPDATE : RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UPDATE: begin
                chain_update = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
        end
    end

    chain_word_shifter #(
        .W (DATA_LEN)
    ) u_shifter (
        .clk         (clk),
        .clear_i     (reset),
        .load_i      (load),
        .load_data_i (bus.cmd_data),
        .shift_i     (shift),
        .serial_i    (chain_data_out),
        .serial_o    (tx_bit),
        .par_o       (bus.rsp_data)
    );

    assign chain_data_in = chain_enable & tx_bit;
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign busy          = (state_q != IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_daisychain_controller.sv
// Directed bench for daisychain_controller driving a real shift_register chain;
// a negedge monitor scores responses, timing and enable/update exclusivity.
`timescale 1ns/1ps
module tb_daisychain_controller;
  import daisychain_pkg::*;

  localparam int N   = DC_DATA_LEN;
  localparam int TMO = 200;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  daisychain_if #(.W(N)) bus ();
  logic          chain_data_in;
  logic          chain_enable;
  logic          chain_update;
  logic          chain_data_out;
  logic          busy;
  ctrl_state_t   dbg_state;
  logic [N-1:0]  bit_out;

  daisychain_controller #(.DATA_LEN(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .chain_data_in  (chain_data_in),
    .chain_enable   (chain_enable),
    .chain_update   (chain_update),
    .chain_data_out (chain_data_out),
    .busy           (busy),
    .dbg_state_o    (dbg_state)
  );

  shift_register #(.DATA_LEN(N)) chain (
    .clk      (clk),
    .reset    (reset),
    .data_in  (chain_data_in),
    .enable   (chain_enable),
    .update   (chain_update),
    .data_out (chain_data_out),
    .bit_out  (bit_out)
  );

  // scoreboard state
  logic [N-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -1000;
  int last_hs = -1000;
  logic last_upd = 1'b0;
  bit chk_acc_after_hs = 1'b0;
  bit chk_spacing = 1'b0;
  int b2b_cnt = 0;
  int en_run = 0;
  logic p_valid = 1'b0;
  logic p_ready = 1'b0;
  logic [N-1:0] p_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      en_run  = 0;
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      check("en_upd_excl", 32'(chain_enable & chain_update), 32'd0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (chk_acc_after_hs) begin
          check("accept_after_rsp", cyc, last_hs + 1);
          chk_acc_after_hs = 1'b0;
        end
        if (chk_spacing) begin
          if (b2b_cnt > 0) check("accept_spacing", cyc - last_acc, N + (last_upd ? 3 : 2));
          b2b_cnt++;
        end
        last_acc = cyc;
        last_upd = bus.cmd_update;
      end
      if (chain_enable) begin
        en_run++;
      end else if (en_run != 0) begin
        check("enable_len", en_run, N);
        en_run = 0;
      end
      if (chain_update) check("update_time", cyc, last_acc + N + 1);
      if (bus.rsp_valid && !p_valid) check("rsp_rise_time", cyc, last_acc + N + (last_upd ? 2 : 1));
      if (bus.rsp_valid && p_valid && !p_ready) check("rsp_stable", 32'(bus.rsp_data), 32'(p_data));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got 0x%0h with empty queue (cycle %0d)", bus.rsp_data, cyc);
        end else begin
          check("rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
        end
        last_hs = cyc;
      end
      p_valid = bus.rsp_valid;
      p_ready = bus.rsp_ready;
      p_data  = bus.rsp_data;
    end
  end

  // driver tasks
  task automatic send(input logic [N-1:0] d, input logic u, input logic [N-1:0] exp_rsp);
    int w = 0;
    exp_q.push_back(exp_rsp);
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_data   = d;
    bus.cmd_update = u;
    while (!bus.cmd_ready && w < TMO) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= TMO) fail_now("cmd_accept");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < TMO) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= TMO) begin
      fail_now("drain");
      exp_q.delete();
    end
  endtask

  initial begin
    bit quiet;
    int w;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = '0;
    bus.cmd_update = 1'b0;
    bus.rsp_ready  = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_enable", 32'(chain_enable), 32'd0);
    check("rst_update", 32'(chain_update), 32'd0);
    check("rst_data_in", 32'(chain_data_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);

    // first word with update; chain was empty
    send(N'(8'hA5), 1'b1, '0);
    wait_drain();
    check("bit_out_after_a5", 32'(bit_out), 32'(N'(8'hA5)));

    // all-ones without update; readback is the first word
    send('1, 1'b0, N'(8'hA5));
    wait_drain();
    check("bit_out_no_update", 32'(bit_out), 32'(N'(8'hA5)));

    // response back-pressure with a second command waiting
    bus.rsp_ready = 1'b0;
    send(N'(8'h3C), 1'b1, '1);
    chk_acc_after_hs = 1'b1;
    fork
      send(N'(8'h5A), 1'b0, N'(8'h3C));
      begin
        w = 0;
        while (!bus.rsp_valid && w < TMO) begin
          @(posedge clk); #1;
          w++;
        end
        if (w >= TMO) fail_now("hold_rsp_valid");
        repeat (5) begin
          @(posedge clk); #1;
          check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
      end
    join
    wait_drain();
    check("bit_out_after_3c", 32'(bit_out), 32'(N'(8'h3C)));

    // reset in the middle of a shift
    send(N'(8'hC3), 1'b1, '0);
    repeat (N / 2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_enable", 32'(chain_enable), 32'd0);
    check("midrst_update", 32'(chain_update), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_bit_out", 32'(bit_out), 32'd0);
    quiet = 1'b1;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (chain_update || bus.rsp_valid || chain_enable) quiet = 1'b0;
    end
    check("midrst_quiet", 32'(quiet), 32'd1);

    // back-to-back, alternating update
    chk_spacing = 1'b1;
    send(N'(8'h12), 1'b1, '0);
    send(N'(8'h34), 1'b0, N'(8'h12));
    send(N'(8'h56), 1'b1, N'(8'h34));
    send(N'(8'h78), 1'b0, N'(8'h56));
    wait_drain();
    chk_spacing = 1'b0;
    check("b2b_accepts", b2b_cnt, 4);
    check("bit_out_after_b2b", 32'(bit_out), 32'(N'(8'h56)));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/daisychain_controller.md
# daisychain_controller

Sequencer for the daisy-chained `shift_register`. It accepts a `DATA_LEN`-bit word over a valid/ready command port and shifts it serially into the chain, LSB first, so that bit i lands in cell i. It then optionally pulses `update` to transfer the chain into the cells' parallel outputs. While shifting, it captures the previous chain contents from the chain's serial output and returns them on a valid/ready response port. It sits between the host/register-file logic and the `shift_register` instance.

## Interface
- `DATA_LEN`, default `` `DATA_LEN `` (from includes.svh): chain length in cells; must be ≥ 2.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept a command.
- `cmd_data` input `DATA_LEN`: word to load into the chain.
- `cmd_update` input 1: 1 = pulse `chain_update` after shifting; 0 = shift/readback only.
- `rsp_valid` output 1: readback word available.
- `rsp_ready` input 1: consumer accepts readback.
- `rsp_data` output `DATA_LEN`: previous chain contents; bit i = old cell i.
- `chain_data_in` output 1: drives the shift_register `data_in`.
- `chain_enable` output 1: drives the shift_register `enable`.
- `chain_update` output 1: drives the shift_register `update`.
- `chain_data_out` input 1: from the shift_register `data_out` (cell 0 serial output).
- `busy` output 1: high in any state other than IDLE.

## Operation
- **States:**
  - IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, load `tx_buf`←`cmd_data`, latch `cmd_update`, set `cnt`←0, go to SHIFT.
  - SHIFT: `chain_enable`=1, `chain_data_in`=`tx_buf[0]`. Each cycle:
    - `tx_buf`←`tx_buf>>1`.
    - `rx_buf`←{`chain_data_out`, `rx_buf[DATA_LEN-1:1]`}.
    - `cnt`++.
    - When `cnt`==`DATA_LEN`-1, go to UPDATE if the latched update bit is 1, else to RESP.
  - UPDATE: `chain_update`=1 and `chain_enable`=0 for exactly one cycle, then go to RESP.
  - RESP: `rsp_valid`=1, `rsp_data`=`rx_buf`. On `rsp_ready`, go to IDLE.
- `chain_data_out` is sampled in the same cycle that `chain_enable` is high, i.e. before the shifting edge. The k-th sample (k=0..`DATA_LEN`-1) is old cell k.
- `chain_enable` and `chain_update` are never high together. Both are 0 in IDLE and RESP.
- `cmd_ready` is 0 in SHIFT, UPDATE and RESP, so only one command is in flight. A command offered while busy is held by the requester; it is not dropped and not accepted.
- `cnt` width is `$clog2(DATA_LEN)`. It does not wrap within a command and is cleared on each accept.
- `rsp_data` stays stable while `rsp_valid`=1 and `rsp_ready`=0.
- **Reset values:**
  - state=IDLE; `cmd_ready`=1 (from the first cycle after reset deasserts).
  - `rsp_valid`=0, `chain_enable`=0, `chain_update`=0, `chain_data_in`=0, `busy`=0.
  - `rsp_data`=0 (`rx_buf`=0), `tx_buf`=0.
- **Reset mid-operation** (SHIFT/UPDATE/RESP): return to IDLE on the next edge. The partial shift is abandoned with no `chain_update` pulse and no response. The chain shares `reset`, so its cells clear too.

## Timing
- Accept edge at cycle T (`cmd_valid`&`cmd_ready` sampled high).
- SHIFT occupies cycles T+1 … T+`DATA_LEN`, with `chain_enable` high for exactly `DATA_LEN` cycles.
- With `cmd_update`=1:
  - `chain_update` is high at T+`DATA_LEN`+1.
  - `rsp_valid` rises at T+`DATA_LEN`+2.
- With `cmd_update`=0: `rsp_valid` rises at T+`DATA_LEN`+1.
- Response handshake at cycle R: `cmd_ready` is high at R+1. The earliest next accept is R+1.
- Back-to-back throughput with `rsp_ready` tied high: one command per `DATA_LEN`+3 cycles (update) or `DATA_LEN`+2 cycles (no update).

## Structure
- Package `daisychain_pkg`:
  - `ctrl_state_t` enum {IDLE, SHIFT, UPDATE, RESP}.
  - `CNT_W` = `$clog2(DATA_LEN)`.
  - `DATA_LEN` is taken from includes.svh.
- One natural sub-module, `chain_word_shifter`: holds `tx_buf`/`rx_buf` with load, shift-enable and clear inputs (parallel-in/serial-out plus serial-in/parallel-out).
- The FSM and counter live in `daisychain_controller`.
- Bench and top level instantiate the controller with a real `shift_register`, wired `chain_*` ↔ `data_in`/`enable`/`update`/`data_out` and a shared `reset`.

## Test plan
- After reset, send `cmd_data`=0xA5 (low byte, rest 0), `cmd_update`=1:
  - `chain_enable` is high for `DATA_LEN` cycles, then `chain_update` pulses once.
  - `bit_out`=`cmd_data`.
  - `rsp_data`=0.
- Second command with `cmd_data`=all-ones, `cmd_update`=0:
  - `rsp_data` equals the first word.
  - `bit_out` is unchanged (no update); the chain cells hold all-ones.
- Hold `rsp_ready`=0 for 5 cycles while `cmd_valid` is high:
  - `rsp_data` stays stable.
  - `cmd_ready`=0 and no second accept occurs.
  - The accept happens at R+1 after `rsp_ready` rises.
- Assert `reset` at SHIFT cycle `DATA_LEN`/2:
  - Next cycle: IDLE, `chain_enable`=0, no `chain_update`, `rsp_valid`=0.
  - `bit_out`=0.
- Back-to-back: 4 commands with `rsp_ready`=1 and alternating `cmd_update`:
  - Each `rsp_data` equals the previously shifted word.
  - The accept spacing matches the Timing section exactly.
- Throughout every test, check the assertion that `chain_enable`&`chain_update` is never 1.
